// File: rtl/aes_key_sched.sv
// AES-128 key schedule: expands a cipher key into 11 round keys held in a readable register file.
// Latency: 10 cycles from key acceptance to keys_valid (20 with AES_KEY_SCHED_SBOX_REG_EN defined).
// Backpressure: key_ready is low while expanding; a key offered then is ignored, not queued.
//
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   clear               - synchronous flush back to IDLE (beats a simultaneous key_valid)
//   key_valid/key_ready - cipher key handshake, key word w0 in key[127:96]
//   busy, keys_valid    - expansion in progress / all round keys stored and stable
//   rd_idx, rd_key      - combinational round-key read, indices 11..15 read as zero
//   sbox_out4/sbox_in4  - word sent to / result from a shared external combinational S-box
//
// Optional build macro AES_KEY_SCHED_SBOX_REG_EN: registers the S-box result so that each
// round takes two cycles (phase 0 looks up, phase 1 writes the round key).

module aes_key_w (
    input  logic [127:0] prev_key,
    input  logic [3:0]   round,
    input  logic [31:0]  sbox_word,
    output logic [127:0] round_key
);
    logic [7:0]  rcon;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // The S-box is fed the unrotated w3; SubWord and RotWord commute, so rotate afterwards.
    assign t  = {sbox_word[23:0], sbox_word[31:24]} ^ {rcon, 24'h000000};
    assign n0 = prev_key[127:96] ^ t;
    assign n1 = prev_key[95:64]  ^ n0;
    assign n2 = prev_key[63:32]  ^ n1;
    assign n3 = prev_key[31:0]   ^ n2;
    assign round_key = {n0, n1, n2, n3};
endmodule

module aes_key_sched #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic [31:0]  sbox_out4,
    input  logic [31:0]  sbox_in4
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   round;
    logic [127:0] rk [0:NUM_ROUNDS];
    logic [127:0] prev_key;
    logic [127:0] round_key;
    logic [31:0]  sbox_word;
    logic         accept;
    logic         step;
    logic         last;

`ifdef AES_KEY_SCHED_SBOX_REG_EN
    logic         phase;
    logic [31:0]  sbox_q;
    assign sbox_word = sbox_q;
    assign step      = (state == EXPAND) && phase;
`else
    assign sbox_word = sbox_in4;
    assign step      = (state == EXPAND);
`endif

    assign accept = key_valid && key_ready && !clear;
    assign last   = (round == 4'(NUM_ROUNDS));

    // Previous round key selected by round-1; round is 1..NUM_ROUNDS whenever it matters.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (round == 4'(i + 1)) prev_key = rk[i];
        end
    end

    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rd_idx == 4'(i)) rd_key = rk[i];
        end
    end

    aes_key_w u_key_w (
        .prev_key  (prev_key),
        .round     (round),
        .sbox_word (sbox_word),
        .round_key (round_key)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        key_ready  = 1'b0;
        busy       = 1'b0;
        keys_valid = 1'b0;
        sbox_out4  = '0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
            end
            EXPAND: begin
                busy      = 1'b1;
                sbox_out4 = prev_key[31:0];
                if (step && last) state_nxt = DONE;
            end
            DONE: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // clear beats acceptance; acceptance beats completion (cannot coincide anyway)
        if (clear)       state_nxt = IDLE;
        else if (accept) state_nxt = EXPAND;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            round <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
`ifdef AES_KEY_SCHED_SBOX_REG_EN
            phase  <= 1'b0;
            sbox_q <= '0;
`endif
        end else if (clear) begin
            round <= '0;
`ifdef AES_KEY_SCHED_SBOX_REG_EN
            phase <= 1'b0;
`endif
        end else if (accept) begin
            rk[0] <= key;
            round <= 4'd1;
`ifdef AES_KEY_SCHED_SBOX_REG_EN
            phase <= 1'b0;
`endif
        end else if (state == EXPAND) begin
`ifdef AES_KEY_SCHED_SBOX_REG_EN
            if (!phase) begin
                sbox_q <= sbox_in4;
                phase  <= 1'b1;
            end else begin
                phase <= 1'b0;
`else
            begin
`endif
                for (int i = 1; i <= NUM_ROUNDS; i++) begin
                    if (round == 4'(i)) rk[i] <= round_key;
                end
                round <= round + 4'd1;
            end
        end
    end
endmodule
